multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle control FSM for the VeriRISC core. It sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback steps, one state per cycle, and stalls on a memory ready handshake. It replaces per-instruction single-cycle decode when instruction and data memory are one port. It drives the PC, IR, register-file, ALU-mux and memory enables.

## Interface
- No parameters; widths fixed: opcode 6, state 4.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `opcode` in 6: IR[31:26]; valid from DECODE onward.
- `zero` in 1: ALU zero flag; used in BRANCH.
- `mem_ready` in 1: memory completes the access this cycle.
- `pc_write` out 1: PC load enable.
- `ir_write` out 1: IR load enable.
- `i_or_d` out 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `mem_to_reg` out 1: writeback source (1 = MDR).
- `reg_dst` out 1: destination register (1 = rd, 0 = rt).
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: ALU A source (0 = PC, 1 = rs).
- `alu_src_b` out 2: ALU B source (00 rt, 01 const 4, 10 imm, 11 imm<<2).
- `alu_op` out 2: 00 add, 01 sub, 10 funct.
- `pc_src` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `illegal` out 1: one-cycle pulse in DECODE for an unknown opcode.
- `instr_done` out 1: pulse on the last cycle of each instruction.
- `state` out 4: current state, for debug.

## Operation
- Opcodes:
  - R 000000
  - LW 100011
  - SW 101011
  - BEQ 000100
  - J 000010
  - Every other opcode is illegal.
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXECUTE 7, ALU_WB 8, BRANCH 9, JUMP 10.
- Transitions:
  - IDLE→FETCH unconditionally.
  - FETCH→DECODE when mem_ready; otherwise stay in FETCH.
  - DECODE: LW/SW→MEM_ADDR, R→EXECUTE, BEQ→BRANCH, J→JUMP, illegal→FETCH.
  - MEM_ADDR→MEM_READ (LW) or MEM_WRITE (SW).
  - MEM_READ→MEM_WB when mem_ready; otherwise hold.
  - MEM_WRITE→FETCH when mem_ready; otherwise hold.
  - EXECUTE→ALU_WB.
  - ALU_WB, MEM_WB, BRANCH and JUMP →FETCH.
- The opcode class is latched into an internal register in DECODE. MEM_ADDR selects its successor from the latched class, not from the live opcode.
- Outputs per state (anything not listed is 0):
  - IDLE: all outputs 0.
  - FETCH: mem_read=1, alu_src_b=01; ir_write = pc_write = mem_ready.
  - DECODE: alu_src_b=11 (branch target into ALUOut); illegal = unknown opcode; instr_done = illegal.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1.
  - MEM_WRITE: mem_write=1, i_or_d=1; instr_done = mem_ready.
  - EXECUTE: alu_src_a=1, alu_op=10.
  - ALU_WB: reg_write=1, reg_dst=1, instr_done=1.
  - BRANCH: alu_src_a=1, alu_op=01, pc_src=01; pc_write = zero; instr_done=1.
  - JUMP: pc_src=10, pc_write=1, instr_done=1.
- Outputs are combinational from state, plus mem_ready/zero gating where noted. There are no glitch requirements beyond synchronous sampling.
- mem_ready is ignored in states that do not access memory.

## Timing
- Reset asserted: state=IDLE immediately (asynchronous). Every output is 0, state=0.
- After reset is released: IDLE for 1 cycle, then FETCH.
- Latency with zero-wait memory (FETCH to instr_done inclusive):
  - R: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ: 3 cycles
  - J: 3 cycles
  - Illegal: 2 cycles
- Each wait cycle of mem_ready adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- During a memory wait, mem_read, mem_write and i_or_d stay stable until the mem_ready cycle.
- Reset mid-instruction: the instruction is aborted with no further writes. Because reset is asynchronous, reg_write, mem_write and pc_write drop in the same cycle.
- BEQ with zero=0: the PC is not written. The PC+4 from FETCH stands.

## Structure
- Shared package `veririsc_pkg`:
  - opcode constants
  - state encodings
  - alu_op codes
  - alu_src_b codes
  - pc_src codes
- Sub-module `opcode_decoder`: combinational, opcode → class {R, MEM_LD, MEM_ST, BR, JMP, ILLEGAL}. Instantiated once.

## Test plan
- Reset held low for 3 cycles, then released → all outputs 0, state=0; the cycle after release, state=1 with mem_read=1.
- R (000000), mem_ready tied 1 → state sequence 1,2,7,8. instr_done and reg_write=1, reg_dst=1 at state 8. Back to state 1 next.
- LW (100011) with mem_ready low for 2 cycles in MEM_READ → mem_read=1, i_or_d=1 held 3 cycles. MEM_WB follows with mem_to_reg=1, reg_write=1. Total 7 cycles.
- BEQ (000100):
  - zero=1 → pc_write=1, pc_src=01 in state 9.
  - zero=0 → pc_write=0 in state 9.
- Opcode 111111 → illegal=1 and instr_done=1 in DECODE, next state FETCH. No reg_write or mem_write at any point.
- SW (101011) with reset pulled low in MEM_WRITE while mem_ready=0 → mem_write drops to 0 the same cycle, state=0.

Source files
------------

// File: rtl/veririsc_pkg.sv
// Shared VeriRISC definitions: opcodes, state encodings, datapath mux codes
// and the opcode class used by the multi-cycle controller.
package veririsc_pkg;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_FETCH     = 4'd1;
  localparam logic [3:0] ST_DECODE    = 4'd2;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd3;
  localparam logic [3:0] ST_MEM_READ  = 4'd4;
  localparam logic [3:0] ST_MEM_WB    = 4'd5;
  localparam logic [3:0] ST_MEM_WRITE = 4'd6;
  localparam logic [3:0] ST_EXECUTE   = 4'd7;
  localparam logic [3:0] ST_ALU_WB    = 4'd8;
  localparam logic [3:0] ST_BRANCH    = 4'd9;
  localparam logic [3:0] ST_JUMP      = 4'd10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_MEM_LD,
    CLS_MEM_ST,
    CLS_BR,
    CLS_JMP,
    CLS_ILLEGAL
  } op_class_e;

  function automatic logic class_is_mem(input op_class_e c);
    return (c == CLS_MEM_LD) || (c == CLS_MEM_ST);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle. The controller side is
// the master (drives control enables); the datapath side is the slave.
interface multicycle_controller_if;

  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
           illegal, instr_done, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
           illegal, instr_done, state
  );

endinterface

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: IR[31:26] -> instruction class.
module opcode_decoder
  import veririsc_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_e  op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OP_R:    op_class = CLS_R;
      OP_LW:   op_class = CLS_MEM_LD;
      OP_SW:   op_class = CLS_MEM_ST;
      OP_BEQ:  op_class = CLS_BR;
      OP_J:    op_class = CLS_JMP;
      default: op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle VeriRISC control FSM: one state per cycle through fetch,
// decode, execute, memory and writeback, stalling on mem_ready.
module multicycle_controller
  import veririsc_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  op_class_e  live_class;
  op_class_e  cls_q;

  opcode_decoder u_opcode_decoder (
    .opcode   (bus.opcode),
    .op_class (live_class)
  );

  // The class is captured in DECODE so MEM_ADDR does not depend on the
  // opcode still being presented a cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_ILLEGAL;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        cls_q <= live_class;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (class_is_mem(live_class)) begin
          state_d = ST_MEM_ADDR;
        end else begin
          case (live_class)
            CLS_R:   state_d = ST_EXECUTE;
            CLS_BR:  state_d = ST_BRANCH;
            CLS_JMP: state_d = ST_JUMP;
            default: state_d = ST_FETCH;
          endcase
        end
      end
      ST_MEM_ADDR:  state_d = (cls_q == CLS_MEM_LD) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (bus.mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WRITE: if (bus.mem_ready) state_d = ST_FETCH;
      ST_EXECUTE:   state_d = ST_ALU_WB;
      ST_MEM_WB,
      ST_ALU_WB,
      ST_BRANCH,
      ST_JUMP:      state_d = ST_FETCH;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_RT;
    bus.alu_op     = ALU_ADD;
    bus.pc_src     = PC_ALU;
    bus.illegal    = 1'b0;
    bus.instr_done = 1'b0;
    bus.state      = state_q;
    case (state_q)
      ST_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      ST_DECODE: begin
        bus.alu_src_b  = SRCB_IMM_SH;
        bus.illegal    = (live_class == CLS_ILLEGAL);
        bus.instr_done = (live_class == CLS_ILLEGAL);
      end
      ST_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
      end
      ST_MEM_WRITE: begin
        bus.mem_write  = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      ST_EXECUTE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
      end
      ST_ALU_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_op     = ALU_SUB;
        bus.pc_src     = PC_ALUOUT;
        bus.pc_write   = bus.zero;
        bus.instr_done = 1'b1;
      end
      ST_JUMP: begin
        bus.pc_src     = PC_JUMP;
        bus.pc_write   = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: a timeline model predicts per-instruction activity
// signatures; a monitor accumulates DUT activity and checks at instr_done.
module tb_multicycle_controller;

  localparam int MAXC    = 8192;
  localparam int N_INSTR = 300;

  typedef struct {
    int done_cyc;
    int memrd, iord, irw, pcw, regw, memw;
    int srca, opfunct, opsub, srcb1, srcb2, srcb3, ill;
    int last_state, last_m2r, last_rdst, last_pcsrc;
  } exp_t;

  typedef struct {
    logic [5:0] opc;
    int         cls;   // 0 R, 1 LW, 2 SW, 3 BEQ, 4 J, 5 illegal
    logic       z;
    int         fw;    // forced fetch waits, -1 = random
    int         mw;    // forced memory waits, -1 = random
  } ins_t;

  logic clk = 1'b0;
  logic reset;
  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = -1;
  int   next_start = 0;
  int   n_issued = 0;
  logic active = 1'b0;
  logic rdy [MAXC];
  exp_t q[$];

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int outs();
    logic [20:0] v;
    v = {bus.pc_write, bus.ir_write, bus.i_or_d, bus.mem_read, bus.mem_write,
         bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
         bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal,
         bus.instr_done, bus.state};
    return int'(v);
  endfunction

  function automatic ins_t pick(input int k);
    ins_t r;
    case (k)
      0: r = '{opc: 6'b000000, cls: 0, z: 1'b0, fw: 0, mw: 0};
      1: r = '{opc: 6'b100011, cls: 1, z: 1'b0, fw: 0, mw: 2};
      2: r = '{opc: 6'b000100, cls: 3, z: 1'b1, fw: 0, mw: 0};
      3: r = '{opc: 6'b000100, cls: 3, z: 1'b0, fw: 0, mw: 0};
      4: r = '{opc: 6'b111111, cls: 5, z: 1'b0, fw: 0, mw: 0};
      5: r = '{opc: 6'b101011, cls: 2, z: 1'b0, fw: 0, mw: 0};
      6: r = '{opc: 6'b000010, cls: 4, z: 1'b1, fw: 2, mw: 0};
      7: r = '{opc: 6'b101011, cls: 2, z: 1'b1, fw: 0, mw: 3};
      default: begin
        r.cls = int'($urandom_range(0, 5));
        r.z   = 1'($urandom_range(0, 1));
        r.fw  = -1;
        r.mw  = -1;
        case (r.cls)
          0: r.opc = 6'b000000;
          1: r.opc = 6'b100011;
          2: r.opc = 6'b101011;
          3: r.opc = 6'b000100;
          4: r.opc = 6'b000010;
          default: begin
            r.opc = 6'($urandom_range(0, 63));
            if (r.opc == 6'b000000 || r.opc == 6'b100011 || r.opc == 6'b101011 ||
                r.opc == 6'b000100 || r.opc == 6'b000010)
              r.opc = 6'b111110;
          end
        endcase
      end
    endcase
    return r;
  endfunction

  // Cycle of the first ready at or after 'from', optionally forcing 'w' waits.
  function automatic int access_end(input int from, input int w);
    int e;
    if (w >= 0) begin
      for (int i = 0; i < w; i++) rdy[from + i] = 1'b0;
      rdy[from + w] = 1'b1;
    end
    e = from;
    while (e < MAXC - 1 && !rdy[e]) e++;
    return e;
  endfunction

  task automatic issue(input ins_t in);
    exp_t e;
    int t, f, d, m, r;
    e = '{default: 0};
    t = cyc;
    f = access_end(t, in.fw);
    d = f + 1;
    e.memrd = f - t + 1;
    e.srcb1 = f - t + 1;
    e.irw   = 1;
    e.pcw   = 1;
    e.srcb3 = 1;
    case (in.cls)
      0: begin
        e.srca = 1; e.opfunct = 1; e.regw = 1;
        e.last_rdst = 1; e.last_state = 8; e.done_cyc = d + 2;
      end
      1: begin
        m = d + 2;
        r = access_end(m, in.mw);
        e.srca = 1; e.srcb2 = 1; e.regw = 1;
        e.memrd += r - m + 1; e.iord = r - m + 1;
        e.last_m2r = 1; e.last_state = 5; e.done_cyc = r + 1;
      end
      2: begin
        m = d + 2;
        r = access_end(m, in.mw);
        e.srca = 1; e.srcb2 = 1;
        e.memw = r - m + 1; e.iord = r - m + 1;
        e.last_state = 6; e.done_cyc = r;
      end
      3: begin
        e.srca = 1; e.opsub = 1; e.pcw += int'(in.z);
        e.last_pcsrc = 1; e.last_state = 9; e.done_cyc = d + 1;
      end
      4: begin
        e.pcw += 1; e.last_pcsrc = 2; e.last_state = 10; e.done_cyc = d + 1;
      end
      default: begin
        e.ill = 1; e.last_state = 2; e.done_cyc = d;
      end
    endcase
    q.push_back(e);
    bus.opcode = in.opc;
    bus.zero   = in.z;
    next_start = e.done_cyc + 1;
  endtask

  // Monitor: accumulate activity per instruction, compare on instr_done.
  initial begin
    exp_t a, e;
    int   idle;
    a = '{default: 0};
    idle = 0;
    forever begin
      @(negedge clk);
      if (active && cyc >= 0) begin
        a.memrd   += int'(bus.mem_read);
        a.iord    += int'(bus.i_or_d);
        a.irw     += int'(bus.ir_write);
        a.pcw     += int'(bus.pc_write);
        a.regw    += int'(bus.reg_write);
        a.memw    += int'(bus.mem_write);
        a.srca    += int'(bus.alu_src_a);
        a.opfunct += int'(bus.alu_op == 2'b10);
        a.opsub   += int'(bus.alu_op == 2'b01);
        a.srcb1   += int'(bus.alu_src_b == 2'b01);
        a.srcb2   += int'(bus.alu_src_b == 2'b10);
        a.srcb3   += int'(bus.alu_src_b == 2'b11);
        a.ill     += int'(bus.illegal);
        if (bus.instr_done) begin
          idle = 0;
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("done_cycle", cyc, e.done_cyc);
            chk("mem_read_cycles", a.memrd, e.memrd);
            chk("i_or_d_cycles", a.iord, e.iord);
            chk("ir_write_count", a.irw, e.irw);
            chk("pc_write_count", a.pcw, e.pcw);
            chk("reg_write_count", a.regw, e.regw);
            chk("mem_write_cycles", a.memw, e.memw);
            chk("alu_src_a_cycles", a.srca, e.srca);
            chk("alu_op_funct", a.opfunct, e.opfunct);
            chk("alu_op_sub", a.opsub, e.opsub);
            chk("src_b_four", a.srcb1, e.srcb1);
            chk("src_b_imm", a.srcb2, e.srcb2);
            chk("src_b_imm_sh", a.srcb3, e.srcb3);
            chk("illegal_count", a.ill, e.ill);
            chk("done_state", int'(bus.state), e.last_state);
            chk("done_mem_to_reg", int'(bus.mem_to_reg), e.last_m2r);
            chk("done_reg_dst", int'(bus.reg_dst), e.last_rdst);
            chk("done_pc_src", int'(bus.pc_src), e.last_pcsrc);
          end
          a = '{default: 0};
        end else begin
          idle++;
          if (idle > 60) begin
            chk("done_timeout", idle, 0);
            idle = 0;
          end
        end
      end
    end
  end

  initial begin
    logic found;
    reset         = 1'b0;
    bus.opcode    = 6'b100011;
    bus.zero      = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < MAXC; i++) rdy[i] = ($urandom_range(0, 99) < 65);
    for (int i = MAXC - 64; i < MAXC; i++) rdy[i] = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 0);
    reset = 1'b1;
    #1 chk("idle_after_release", outs(), 0);

    active = 1'b1;
    forever begin
      @(posedge clk);
      #1 cyc++;
      if (cyc == next_start && n_issued < N_INSTR) begin
        issue(pick(n_issued));
        n_issued++;
      end
      bus.mem_ready = rdy[cyc];
      if (cyc == 0) begin
        @(negedge clk);
        chk("first_state_fetch", int'(bus.state), 1);
        chk("first_mem_read", int'(bus.mem_read), 1);
      end
      if (n_issued == N_INSTR && cyc >= next_start) break;
      if (cyc >= MAXC - 2) break;
    end
    active = 1'b0;
    chk("scoreboard_drain", q.size(), 0);

    // SW aborted by reset while stalled in MEM_WRITE
    @(negedge clk);
    reset = 1'b0;
    #1 chk("reset2_outputs", outs(), 0);
    bus.opcode    = 6'b101011;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (bus.state > 4'd1) bus.mem_ready = 1'b0;
      if (bus.state == 4'd6) found = 1'b1;
    end
    chk("sw_reach_mem_write", int'(found), 1);
    chk("sw_mem_write", int'(bus.mem_write), 1);
    chk("sw_i_or_d", int'(bus.i_or_d), 1);
    chk("sw_no_done_while_wait", int'(bus.instr_done), 0);
    @(negedge clk);
    chk("sw_stall_state", int'(bus.state), 6);
    chk("sw_stall_mem_write", int'(bus.mem_write), 1);
    #2 reset = 1'b0;
    #1 chk("sw_abort_outputs", outs(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
